ir_key_ctrl: RTL and testbench
==============================

# ir_key_ctrl

Key-event controller that sits behind the NEC/HT6221 IR frame decoder and sequences its output into clean key events for the application. It validates each decoded frame, filters by device address, and tracks press/hold/release from repeat codes. It generates auto-repeat hold events and queues events in a small FIFO with a valid/ready handshake toward the consumer.

## Interface
- `DEV_ADDR`, default 16'h00FF: expected 16-bit address field of accepted frames.
- `HOLD_DELAY_CYC`, default 25_000_000: cycles from first press to first hold event (500 ms at 50 MHz).
- `REPEAT_GAP_CYC`, default 6_000_000: cycles without a repeat code before release is declared (120 ms at 50 MHz).
- `FIFO_DEPTH`, default 4: key-event FIFO entries; must be a power of 2, ≥2.
- `clk`  in  1: system clock; one clock domain, everything on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `frm_valid`  in  1: one-cycle pulse from the decoder; a full 32-bit frame is on `frm_addr`/`frm_data`.
- `frm_addr`  in  16: decoded address field.
- `frm_data`  in  16: decoded data field; [7:0] is the command, [15:8] is its complement.
- `rpt_valid`  in  1: one-cycle pulse from the decoder when a repeat code (9 ms + 2.25 ms) is received.
- `key_valid`  out  1: FIFO not empty.
- `key_code`  out  8: command byte at the FIFO head.
- `key_hold`  out  1: head entry is a hold (auto-repeat) event.
- `key_ready`  in  1: consumer accepts the head entry when `key_valid && key_ready`.
- `key_release`  out  1: one-cycle pulse when the held key is released.
- `key_active`  out  1: a key is currently pressed or held.
- `err_cnt`  out  8: saturating count of rejected frames (complement or address mismatch).
- `drop_cnt`  out  8: saturating count of events lost because the FIFO was full.

## Operation
- The FSM has three states: IDLE, PRESS and HOLD. Reset state is IDLE.
- **Frame check:** a frame is good when `frm_data[15:8] == ~frm_data[7:0]` and the address filter passes.
- **Bad frame:** increment `err_cnt`; the state does not change.
- **Good frame, any state:** push {code, hold=0}, latch the code, clear the gap and hold counters, and go to PRESS.
  - If the previous state was PRESS or HOLD, no `key_release` pulse is generated (new key replaces the old one).
- **`rpt_valid` in IDLE:** ignored, with no count.
- **`rpt_valid` in PRESS:** clear the gap counter only.
- **`rpt_valid` in HOLD:** clear the gap counter and push {latched code, hold=1}.
- **PRESS:** the hold counter increments every cycle. When it reaches `HOLD_DELAY_CYC-1`, push {code, hold=1} and go to HOLD.
- **PRESS or HOLD:** the gap counter increments every cycle. When it reaches `REPEAT_GAP_CYC-1`, pulse `key_release` and go to IDLE.
- **Simultaneous events, same cycle:**
  - Good frame beats repeat, gap expiry and hold expiry.
  - `rpt_valid` beats gap expiry; the gap counter clears and the state is kept.
  - Hold expiry together with `rpt_valid`: exactly one hold push.
- **FIFO:** show-ahead; the head is always driven on `key_code`/`key_hold`.
  - Push and pop in the same cycle are both performed, including when full.
  - A push while full without a pop is dropped and increments `drop_cnt`.
  - `err_cnt` and `drop_cnt` saturate at 255.
- `key_active` is 1 in PRESS or HOLD.
- **Counter widths:** `$clog2` of the respective parameter.
- **Reset mid-operation:** asynchronously returns to IDLE. The FIFO is emptied, the counters clear, and no release pulse is generated.

## Timing
- **Reset values:** `key_valid`=0, `key_code`=0, `key_hold`=0, `key_release`=0, `key_active`=0, `err_cnt`=0, `drop_cnt`=0.
- **Frame latency:** good `frm_valid` in cycle N gives `key_valid`=1 and `key_active`=1 in cycle N+1.
- **Hold latency:** the first hold event appears `HOLD_DELAY_CYC` cycles after the frame cycle, plus 1 for the FIFO register.
- **Release:** `key_release` is asserted in cycle M+`REPEAT_GAP_CYC`, where M is the last press or repeat cycle. `key_active` drops in the same cycle.
- **Consumer handshake:** the head advances on the edge after `key_valid && key_ready`. Back-to-back pops are allowed with `key_ready` held high.
- **Input rules:** `frm_valid` and `rpt_valid` are single-cycle pulses and are never asserted together by the decoder. If both are asserted, the frame wins.

## Configuration
- Macro: `IR_ADDR_FILTER_EN`.
- **Defined:** frames with `frm_addr != DEV_ADDR` are rejected and counted in `err_cnt`.
- **Undefined:** `frm_addr` is ignored; only the complement check applies, and `DEV_ADDR` is unused.

## Test plan
All scenarios use `HOLD_DELAY_CYC`=300, `REPEAT_GAP_CYC`=100, `FIFO_DEPTH`=4 and `key_ready`=1 unless stated otherwise.
1. **Single press:** frame addr=00FF, data=BA45 → one event {45, hold=0} one cycle later; no repeats → `key_release` pulses 100 cycles after the frame; `key_active` is then 0.
2. **Bad complement:** data=BB45 → no event, `err_cnt`=1, state stays IDLE. With the macro defined, addr=1234 → `err_cnt`=2.
3. **Hold:** frame data=E916, then `rpt_valid` every 90 cycles for 1000 cycles → first {16, hold=1} at about +301, then one hold event per repeat, and release 100 cycles after the last repeat.
4. **FIFO full:** `key_ready`=0, six good frames, each with a different code → `key_valid`=1, first 4 codes retained in order, `drop_cnt`=2. Then `key_ready`=1 → 4 events in 4 consecutive cycles.
5. **Simultaneous events:** `rpt_valid` in the exact gap-expiry cycle → no release, state kept. A frame in the same cycle as a hold expiry → {code, hold=0} only.
6. **Reset mid-hold:** `rst` pulsed high while in HOLD with 2 entries queued → outputs return to reset values immediately; no `key_release` pulse.

Source files
------------

// File: rtl/ir_key_ctrl.sv
// rtl/ir_key_ctrl.sv - IR key-event controller (optional address filter: IR_ADDR_FILTER_EN)
module ir_key_ctrl #(
    parameter logic [15:0] DEV_ADDR       = 16'h00FF,
    parameter int          HOLD_DELAY_CYC = 25_000_000,
    parameter int          REPEAT_GAP_CYC = 6_000_000,
    parameter int          FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frm_valid,
    input  logic [15:0] frm_addr,
    input  logic [15:0] frm_data,
    input  logic        rpt_valid,
    output logic        key_valid,
    output logic [7:0]  key_code,
    output logic        key_hold,
    input  logic        key_ready,
    output logic        key_release,
    output logic        key_active,
    output logic [7:0]  err_cnt,
    output logic [7:0]  drop_cnt
);

    localparam int HW = (HOLD_DELAY_CYC > 1) ? $clog2(HOLD_DELAY_CYC) : 1;
    localparam int GW = (REPEAT_GAP_CYC > 1) ? $clog2(REPEAT_GAP_CYC) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_DELAY_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(REPEAT_GAP_CYC - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [HW-1:0] hold_cnt;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    code_q;

    logic          addr_ok;
    logic          frm_good;
    logic          rpt_hit;
    logic          push;
    logic          push_hold;
    logic          gap_clr;
    logic          hold_clr;
    logic          release_now;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          drop;
    logic [7:0]    push_code;

`ifdef IR_ADDR_FILTER_EN
    assign addr_ok = (frm_addr == DEV_ADDR);
`else
    // Address field and DEV_ADDR are intentionally ignored in this build.
    logic unused_addr;
    assign unused_addr = ^{frm_addr, DEV_ADDR};
    assign addr_ok     = 1'b1;
`endif

    assign frm_good  = frm_valid && addr_ok && (frm_data[15:8] == ~frm_data[7:0]);
    // A frame (good or bad) in the same cycle masks any repeat pulse.
    assign rpt_hit   = rpt_valid && !frm_valid;
    assign push_code = frm_good ? frm_data[7:0] : code_q;

    // State register; reset always lands in IDLE without a release pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and event decisions: good frame > repeat > gap expiry > hold expiry.
    always_comb begin
        state_next  = state;
        push        = 1'b0;
        push_hold   = 1'b0;
        gap_clr     = 1'b0;
        hold_clr    = 1'b0;
        release_now = 1'b0;
        if (frm_good) begin
            push       = 1'b1;
            gap_clr    = 1'b1;
            hold_clr   = 1'b1;
            state_next = PRESS;
        end else if (state != IDLE) begin
            if (rpt_hit) begin
                gap_clr = 1'b1;
                if (state == HOLD) begin
                    push      = 1'b1;
                    push_hold = 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    push       = 1'b1;
                    push_hold  = 1'b1;
                    state_next = HOLD;
                end
            end else if (gap_cnt == GAP_LAST) begin
                release_now = 1'b1;
                state_next  = IDLE;
            end else if (state == PRESS && hold_cnt == HOLD_LAST) begin
                push       = 1'b1;
                push_hold  = 1'b1;
                state_next = HOLD;
            end
        end
    end

    // Gap and hold timers plus the latched command byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt  <= '0;
            hold_cnt <= '0;
            code_q   <= '0;
        end else begin
            if (gap_clr)             gap_cnt <= '0;
            else if (state != IDLE)  gap_cnt <= gap_cnt + 1'b1;
            if (hold_clr)            hold_cnt <= '0;
            else if (state == PRESS) hold_cnt <= hold_cnt + 1'b1;
            if (frm_good)            code_q <= frm_data[7:0];
        end
    end

    // Saturating error counter for rejected frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          err_cnt <= '0;
        else if (frm_valid && !frm_good && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end

    assign pop   = key_valid && key_ready;
    assign full  = (count == FIFO_FULL);
    // When full, a simultaneous pop frees the slot being written.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    // FIFO storage; contents need no reset since count gates the outputs.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {push_hold, push_code};
    end

    // FIFO pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign key_valid   = (count != '0);
    assign key_code    = key_valid ? mem[rd_ptr][7:0] : 8'h00;
    assign key_hold    = key_valid ? mem[rd_ptr][8]   : 1'b0;
    assign key_release = release_now;
    assign key_active  = (state != IDLE) && !release_now;

endmodule

// File: tb/tb_ir_key_ctrl.sv
// tb/tb_ir_key_ctrl.sv - randomized self-checking bench for ir_key_ctrl
module tb_ir_key_ctrl;

    localparam int H = 300;
    localparam int G = 100;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frm_valid = 1'b0;
    logic [15:0] frm_addr = 16'h0000;
    logic [15:0] frm_data = 16'h0000;
    logic        rpt_valid = 1'b0;
    logic        key_ready = 1'b0;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        key_hold;
    logic        key_release;
    logic        key_active;
    logic [7:0]  err_cnt;
    logic [7:0]  drop_cnt;

    ir_key_ctrl #(
        .DEV_ADDR       (16'h00FF),
        .HOLD_DELAY_CYC (H),
        .REPEAT_GAP_CYC (G),
        .FIFO_DEPTH     (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frm_valid   (frm_valid),
        .frm_addr    (frm_addr),
        .frm_data    (frm_data),
        .rpt_valid   (rpt_valid),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_hold    (key_hold),
        .key_ready   (key_ready),
        .key_release (key_release),
        .key_active  (key_active),
        .err_cnt     (err_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: key state kept as timestamps, event FIFO as a queue.
    bit          m_active;
    bit          m_holding;
    logic [7:0]  m_code;
    longint      m_press;
    longint      m_last;
    int          m_err;
    int          m_drop;
    logic [8:0]  q[$];
    longint      t = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [7:0] c);
        logic [7:0] inv;
        inv = ~c;
        return {inv, c};
    endfunction

    task automatic model_reset();
        m_active  = 0;
        m_holding = 0;
        m_code    = 8'h00;
        m_press   = 0;
        m_last    = 0;
        m_err     = 0;
        m_drop    = 0;
        q.delete();
    endtask

    // One clock cycle: drive inputs, compare all outputs to the model, advance the model.
    task automatic step(input bit f, input logic [15:0] a, input logic [15:0] d,
                        input bit r, input bit rdy);
        bit         addr_ok, good, r_eff, rel, hx, ev, pop, push;
        logic [7:0] lo, hi_exp;
        logic [8:0] pval;
        int         sz;
        @(posedge clk);
        #1;
        frm_valid = f;
        frm_addr  = a;
        frm_data  = d;
        rpt_valid = r;
        key_ready = rdy;
        @(negedge clk);
`ifdef IR_ADDR_FILTER_EN
        addr_ok = (a == 16'h00FF);
`else
        addr_ok = 1'b1;
`endif
        lo     = d[7:0];
        hi_exp = ~lo;
        good   = f && addr_ok && (d[15:8] == hi_exp);
        r_eff  = r && !f;
        rel    = m_active && !good && !r_eff && (t - m_last == G);
        hx     = m_active && !m_holding && !good && !rel && (t - m_press == H);
        ev     = (q.size() != 0);
        check("key_valid",   key_valid,   ev);
        check("key_code",    key_code,    ev ? q[0][7:0] : 8'h00);
        check("key_hold",    key_hold,    ev ? q[0][8] : 1'b0);
        check("key_release", key_release, rel);
        check("key_active",  key_active,  m_active && !rel);
        check("err_cnt",     err_cnt,     m_err);
        check("drop_cnt",    drop_cnt,    m_drop);
        pop  = ev && rdy;
        push = 0;
        pval = '0;
        if (good) begin
            push      = 1;
            pval      = {1'b0, lo};
            m_active  = 1;
            m_holding = 0;
            m_code    = lo;
            m_press   = t;
            m_last    = t;
        end else begin
            if (f && m_err < 255) m_err++;
            if (m_active) begin
                if (rel) begin
                    m_active  = 0;
                    m_holding = 0;
                end else begin
                    if (r_eff) begin
                        m_last = t;
                        if (m_holding) begin
                            push = 1;
                            pval = {1'b1, m_code};
                        end
                    end
                    if (hx) begin
                        push      = 1;
                        pval      = {1'b1, m_code};
                        m_holding = 1;
                    end
                end
            end
        end
        sz = q.size();
        if (pop) void'(q.pop_front());
        if (push) begin
            if (sz < D || pop) q.push_back(pval);
            else if (m_drop < 255) m_drop++;
        end
        t++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 16'h0, 16'h0, 0, rdy);
    endtask

    initial begin
        int nrnd;
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_key_valid",   key_valid,   1'b0);
        check("rst_key_code",    key_code,    8'h00);
        check("rst_key_hold",    key_hold,    1'b0);
        check("rst_key_release", key_release, 1'b0);
        check("rst_key_active",  key_active,  1'b0);
        check("rst_err_cnt",     err_cnt,     8'h00);
        check("rst_drop_cnt",    drop_cnt,    8'h00);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single press, natural release after the gap.
        step(1, 16'h00FF, 16'hBA45, 0, 1);
        idle(130, 1);

        // Bad complement, then (filtered build) wrong address.
        step(1, 16'h00FF, 16'hBB45, 0, 1);
        step(1, 16'h1234, 16'hBA45, 0, 1);
        idle(5, 1);

        // Hold with repeats every 90 cycles for ~1000 cycles.
        step(1, 16'h00FF, 16'hE916, 0, 1);
        for (int i = 1; i < 1000; i++) step(0, 16'h0, 16'h0, (i % 90) == 0, 1);
        idle(120, 1);

        // FIFO full: six frames with the consumer stalled, then drain.
        step(1, 16'h00FF, mk(8'h11), 0, 0);
        step(1, 16'h00FF, mk(8'h22), 0, 0);
        step(1, 16'h00FF, mk(8'h33), 0, 0);
        step(1, 16'h00FF, mk(8'h44), 0, 0);
        step(1, 16'h00FF, mk(8'h55), 0, 0);
        step(1, 16'h00FF, mk(8'h66), 0, 0);
        idle(1, 0);
        check("s4_drop_cnt", drop_cnt, 8'd2);
        check("s4_head",     key_code, 8'h11);
        idle(10, 1);
        check("s4_drained",  key_valid, 1'b0);
        idle(100, 1);

        // Repeat in the exact gap-expiry cycle, then a frame on hold expiry.
        step(1, 16'h00FF, mk(8'h5A), 0, 1);
        for (int i = 1; i < 300; i++)
            step(0, 16'h0, 16'h0, (i == 100) || (i == 190) || (i == 280), 1);
        step(1, 16'h00FF, mk(8'hA7), 0, 1);
        idle(120, 1);

        // Reset in HOLD with two queued entries.
        step(1, 16'h00FF, mk(8'h3C), 0, 0);
        for (int i = 1; i < 305; i++)
            step(0, 16'h0, 16'h0, (i == 90) || (i == 180) || (i == 270), 0);
        idle(1, 0);
        check("s6_active_before", key_active, 1'b1);
        check("s6_valid_before",  key_valid,  1'b1);
        #1 rst = 1'b1;
        #1;
        check("s6_rst_valid",   key_valid,   1'b0);
        check("s6_rst_code",    key_code,    8'h00);
        check("s6_rst_hold",    key_hold,    1'b0);
        check("s6_rst_release", key_release, 1'b0);
        check("s6_rst_active",  key_active,  1'b0);
        check("s6_rst_err",     err_cnt,     8'h00);
        check("s6_rst_drop",    drop_cnt,    8'h00);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        idle(5, 1);

        // Randomized traffic.
        nrnd = 4000;
        for (int i = 0; i < nrnd; i++) begin
            int          sel;
            logic [7:0]  c;
            logic [15:0] a, dd;
            sel = $urandom_range(0, 99);
            c   = 8'($urandom);
            a   = ($urandom_range(0, 9) < 8) ? 16'h00FF : 16'($urandom);
            dd  = ($urandom_range(0, 9) < 8) ? mk(c) : 16'($urandom);
            if (sel < 2)       step(1, a, dd, 0, $urandom_range(0, 3) != 0);
            else if (sel < 5)  step(0, 16'h0, 16'h0, 1, $urandom_range(0, 3) != 0);
            else               step(0, 16'h0, 16'h0, 0, $urandom_range(0, 3) != 0);
        end
        idle(5, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL timeout cycle=%0d got=running exp=finished", t);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
